timer_irq: RTL
==============

# timer_irq

Memory-mapped countdown timer on the CPU's device bus and the source side of the hardware-interrupt path. Software programs a preset and a control word through word-aligned stores. The block counts down once per clock and raises `irq`, which drives `HWInt[2]` of CP0. It supports one-shot and auto-reload modes.

## Interface
- No parameters; register width fixed at 32.
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `we`  in  1  write strobe for the addressed register.
- `addr`  in  2  word address: 0 CTRL, 1 PRESET, 2 COUNT (read-only), 3 unused.
- `din`  in  32  write data.
- `dout`  out  32  combinational read data for `addr`.
- `irq`  out  1  interrupt request, `irq_flag & CTRL.IM`.

## Operation
- CTRL fields:
  - bit0 `EN`.
  - bits[2:1] `MODE`: 0 is one-shot, 1 is auto-reload, 2/3 behave as 0.
  - bit3 `IM`: interrupt mask, 1 enables `irq`.
  - Bits 31:4 ignore writes and read as 0.
- PRESET: 32-bit reload value. COUNT: 32-bit down-counter; writes to addr 2 or 3 are ignored.
- `dout`: addr 0 gives `{28'b0, IM, MODE, EN}`, addr 1 gives PRESET, addr 2 gives COUNT, addr 3 gives 0.
- State machine states are IDLE, LOAD, CNT and INT.
  - IDLE: if `EN`, go to LOAD. COUNT holds.
  - LOAD: COUNT <= PRESET, go to CNT.
  - CNT: if `!EN`, go to IDLE with COUNT frozen. Otherwise:
    - if COUNT > 1, COUNT <= COUNT-1;
    - else (COUNT is 1 or 0), COUNT <= 0, `irq_flag` <= 1, go to INT.
  - INT, MODE 0: `EN` <= 0, go to IDLE. `irq_flag` stays set.
  - INT, MODE 1: `irq_flag` <= 0, go to LOAD, so `irq_flag` is high exactly one cycle. If `EN` was cleared meanwhile, go to IDLE.
- `irq_flag` is cleared by any write to CTRL or PRESET.
  - If a clear and a set occur on the same edge, the set wins.
- A CPU write to CTRL on the same edge as the hardware `EN` clear in INT wins; the written value is kept.
- A PRESET write during CNT does not affect the running count. It takes effect at the next LOAD.
- COUNT arithmetic is unsigned 32-bit and never wraps below 0.

## Timing
- Reset (`reset`=0, asynchronous):
  - CTRL, PRESET, COUNT and `irq_flag` are all 0; state is IDLE.
  - `irq`=0 and `dout`=0 for every `addr`.
  - Release is sampled synchronously; first state change at the first edge after deassertion.
- Register writes take effect at the edge where `we`=1. Reads are same-cycle combinational.
- Define E0 as the edge that writes `EN`=1 (PRESET=N already loaded):
  - E1: go to LOAD.
  - E2: COUNT=N, state CNT.
  - E2+k: COUNT=N−k.
  - E2+N: state INT, `irq_flag`=1.
  - N=0 behaves as N=1.
- Latency from the enable write to `irq` is N+2 edges.
- MODE 1 period: `irq` is high one cycle every N+2 cycles.
- Reset asserted mid-count: immediate return to reset values, and `irq` drops the same instant.

## Test plan
- Reset → `irq`=0; reading addr 0, 1 and 2 each returns 0. Write COUNT=5 (addr 2) → read COUNT still 0.
- One-shot: PRESET=3, CTRL=0x9 (IM=1, MODE 0, EN=1) at E0 → COUNT reads 3,2,1 after E2,E3,E4; `irq`=1 from E5 and held. CTRL then reads 0x8. A write of PRESET=3 drops `irq` next cycle.
- Auto-reload: PRESET=2, CTRL=0xB → `irq` high for one cycle after E4, E8, E12 (period 4). CTRL `EN` stays 1.
- Mask: PRESET=1, CTRL=0x1 → `irq_flag` sets after E3 but `irq`=0. Writing CTRL=0x8 clears the flag, so `irq` remains 0.
- Disable mid-count: PRESET=10, EN=1, then write CTRL=0x8 when COUNT=6 → COUNT frozen at 5 or 6 per edge order, state IDLE, no `irq`.
- Async reset while COUNT=4 in MODE 1 → all registers 0 and `irq`=0 with no clock edge required.

Source files
------------

// File: rtl/timer_irq.sv
// Memory-mapped countdown timer (one-shot / auto-reload) driving HWInt[2]; irq asserts N+2 edges after EN write.
// Reads are combinational; writes take effect on the strobed edge, no stall path.
module timer_irq (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state;
  logic        en;
  logic [1:0]  mode;
  logic        im;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;

  logic wr_ctrl;
  logic wr_preset;
  logic reload;

  assign wr_ctrl   = we && (addr == 2'd0);
  assign wr_preset = we && (addr == 2'd1);
  assign reload    = (mode == 2'd1);
  assign irq       = irq_flag & im;

  always_comb begin
    dout = 32'd0;
    case (addr)
      2'd0:    dout = {28'd0, im, mode, en};
      2'd1:    dout = preset;
      2'd2:    dout = count;
      default: dout = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      en       <= 1'b0;
      mode     <= 2'd0;
      im       <= 1'b0;
      preset   <= 32'd0;
      count    <= 32'd0;
      irq_flag <= 1'b0;
    end else begin
      // Bus clear comes first so a same-edge hardware set overrides it.
      if (wr_ctrl || wr_preset)
        irq_flag <= 1'b0;

      case (state)
        IDLE: if (en) state <= LOAD;
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!en) begin
            state <= IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            count    <= 32'd0;
            irq_flag <= 1'b1;
            state    <= INT;
          end
        end
        INT: begin
          if (reload) begin
            irq_flag <= 1'b0;
            state    <= en ? LOAD : IDLE;
          end else begin
            en    <= 1'b0;
            state <= IDLE;
          end
        end
      endcase

      // A CPU write to CTRL overrides the one-shot EN clear on the same edge.
      if (wr_ctrl) begin
        en   <= din[0];
        mode <= din[2:1];
        im   <= din[3];
      end
      if (wr_preset)
        preset <= din;
    end
  end

endmodule
